// File: rtl/poro_pkg.sv
// Shared types and constants for the poro target logic: state encoding,
// screen and spawn-row bounds, and the LFSR seed/taps used by poro spawners.
package poro_pkg;

   typedef enum logic [1:0] {
      S_WAIT   = 2'd0,
      S_ROAM   = 2'd1,
      S_CAUGHT = 2'd2
   } poro_state_t;

   localparam logic [8:0] SCREEN_W  = 9'd320;
   localparam logic [7:0] SCREEN_H  = 8'd240;
   localparam logic [7:0] Y_MIN     = 8'd70;
   localparam logic [7:0] Y_SPAN    = 8'd90;
   localparam logic [8:0] SPEED_MAX = 9'd4;

   localparam logic [7:0] LFSR_SEED = 8'hA5;
   // Taps 8,6,5,4 as a bit mask on lfsr[7:0].
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   // Rows past the span fold back by 64 so every row stays within Y_MIN..Y_MIN+Y_SPAN.
   function automatic logic [7:0] spawn_row(input logic [7:0] lfsr);
      logic [7:0] r;
      r = {1'b0, lfsr[6:0]};
      if (r <= Y_SPAN)
         spawn_row = Y_MIN + r;
      else
         spawn_row = Y_MIN + r - 8'd64;
   endfunction

endpackage

// File: rtl/poro_lfsr.sv
// Free-running 8-bit Fibonacci LFSR that also presents the spawn row
// derived from its current value.
module poro_lfsr
   import poro_pkg::*;
(
   input  logic       clk,
   input  logic       resetn,
   output logic [7:0] lfsr,
   output logic [7:0] row
);

   logic fb;

   assign fb  = ^(lfsr & LFSR_TAPS);
   assign row = spawn_row(lfsr);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         lfsr <= LFSR_SEED;
      else
         lfsr <= {lfsr[6:0], fb};
   end

endmodule

// File: rtl/poro_catch.sv
// Poro target: spawn, roam, hook collision and drag-back scoring.
// Optional PORO_SPEEDUP_EN: roaming speed grows with score, capped at 4 px/frame.
//
//   state    | meaning
//   S_WAIT   | poro hidden, counting frames until respawn
//   S_ROAM   | poro visible, walking left, hit checked every cycle
//   S_CAUGHT | poro follows the hook tip until delivered or hook drops
module poro_catch
   import poro_pkg::*;
#(
   parameter logic [8:0] SPAWN_X     = 9'd300,
   parameter logic [8:0] ESCAPE_X    = 9'd40,
   parameter logic [8:0] DELIVER_X   = 9'd42,
   parameter logic [8:0] PORO_V      = 9'd1,
   parameter logic [8:0] HIT_W       = 9'd6,
   parameter logic [7:0] HIT_H       = 8'd6,
   parameter logic [5:0] SPAWN_DELAY = 6'd30
)
(
   input  logic       clk,
   input  logic       resetn,
   input  logic       frame,
   input  logic [8:0] hook_x,
   input  logic [7:0] hook_y,
   output logic [8:0] poro_x,
   output logic [7:0] poro_y,
   output logic       poro_visible,
   output logic       grab_success,
   output logic [7:0] score,
   output logic [7:0] missed
);

   poro_state_t state, state_nxt;
   logic [5:0]  cnt, cnt_nxt;
   logic [8:0]  x_nxt;
   logic [7:0]  y_nxt, score_nxt, missed_nxt;
   logic        grab_nxt, vis_nxt;
   logic [7:0]  lfsr, row;
   logic [8:0]  speed;
   logic signed [9:0] dx, dy;
   logic [9:0]  adx, ady;
   logic        hit;

   poro_lfsr u_lfsr (
      .clk    (clk),
      .resetn (resetn),
      .lfsr   (lfsr),
      .row    (row)
   );

   assign dx  = $signed({1'b0, hook_x}) - $signed({1'b0, poro_x});
   assign dy  = $signed({2'b00, hook_y}) - $signed({2'b00, poro_y});
   assign adx = dx[9] ? 10'(-dx) : 10'(dx);
   assign ady = dy[9] ? 10'(-dy) : 10'(dy);
   assign hit = (hook_y != 8'd0) && (adx < {1'b0, HIT_W}) && (ady < {2'b00, HIT_H});

`ifdef PORO_SPEEDUP_EN
   logic [8:0] speed_sum;
   assign speed_sum = PORO_V + {4'b0000, score[7:3]};
   assign speed     = (speed_sum > SPEED_MAX) ? SPEED_MAX : speed_sum;
`else
   assign speed = PORO_V;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state        <= S_WAIT;
         cnt          <= 6'd0;
         poro_x       <= 9'd0;
         poro_y       <= 8'd0;
         poro_visible <= 1'b0;
         grab_success <= 1'b0;
         score        <= 8'd0;
         missed       <= 8'd0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         poro_x       <= x_nxt;
         poro_y       <= y_nxt;
         poro_visible <= vis_nxt;
         grab_success <= grab_nxt;
         score        <= score_nxt;
         missed       <= missed_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      x_nxt      = poro_x;
      y_nxt      = poro_y;
      score_nxt  = score;
      missed_nxt = missed;
      grab_nxt   = 1'b0;
      case (state)
         S_WAIT: begin
            if (frame) begin
               if (cnt == 6'(SPAWN_DELAY - 6'd1)) begin
                  x_nxt     = SPAWN_X;
                  y_nxt     = row;
                  cnt_nxt   = 6'd0;
                  state_nxt = S_ROAM;
               end else begin
                  cnt_nxt = cnt + 6'd1;
               end
            end
         end
         S_ROAM: begin
            // A hit outranks an escape on the same frame.
            if (hit) begin
               grab_nxt  = 1'b1;
               state_nxt = S_CAUGHT;
            end else if (frame) begin
               if (poro_x <= ESCAPE_X) begin
                  if (missed != 8'hFF)
                     missed_nxt = missed + 8'd1;
                  state_nxt = S_WAIT;
               end else begin
                  x_nxt = poro_x - speed;
               end
            end
         end
         S_CAUGHT: begin
            x_nxt = hook_x;
            y_nxt = hook_y;
            if ((hook_x <= DELIVER_X) || (hook_y == 8'd0)) begin
               if (score != 8'hFF)
                  score_nxt = score + 8'd1;
               state_nxt = S_WAIT;
            end
         end
         default: state_nxt = S_WAIT;
      endcase
      vis_nxt = (state_nxt != S_WAIT);
   end

endmodule
